// File: rtl/line_pkg.sv
// Shared definitions for the line command queue: default widths,
// dispatcher states and the packed segment layout {x0, y0, x1, y1, col}.
package line_pkg;

  localparam int XW_DEF    = 9;
  localparam int YW_DEF    = 8;
  localparam int CW_DEF    = 3;
  localparam int DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } disp_state_t;

  function automatic int seg_width(input int xw, input int yw, input int cw);
    return 2 * xw + 2 * yw + cw;
  endfunction

endpackage

// File: rtl/line_cmd_fifo.sv
// First-word fall-through segment FIFO with registered occupancy/full/empty.
// A push while full is accepted only when a pop happens at the same edge.
module line_cmd_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(DEPTH);

  logic [W-1:0]    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CNTW-1:0] cnt_nxt;
  logic            do_push;
  logic            do_pop;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_comb begin
    cnt_nxt = count;
    case ({do_push, do_pop})
      2'b10:   cnt_nxt = count + CNT_ONE;
      2'b01:   cnt_nxt = count - CNT_ONE;
      default: cnt_nxt = count;
    endcase
  end

  // Storage carries no reset; occupancy alone defines what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count <= cnt_nxt;
      full  <= (cnt_nxt == CNT_FULL);
      empty <= (cnt_nxt == '0);
    end
  end

endmodule

// File: rtl/line_cmd_queue.sv
// Polyline command queue: captures user points, forms segments on each go edge,
// buffers them and dispatches one at a time to the line drawer via start/done.
module line_cmd_queue
  import line_pkg::*;
#(
  parameter int XW    = XW_DEF,
  parameter int YW    = YW_DEF,
  parameter int CW    = CW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [XW-1:0]          i_val,
  input  logic                   i_setx,
  input  logic                   i_sety,
  input  logic                   i_setcol,
  input  logic                   i_go,
  input  logic                   i_penup,
  input  logic                   i_done,
  output logic [XW-1:0]          o_x0,
  output logic [XW-1:0]          o_x1,
  output logic [YW-1:0]          o_y0,
  output logic [YW-1:0]          o_y1,
  output logic [CW-1:0]          o_color,
  output logic                   o_start,
  output logic [XW-1:0]          o_xin,
  output logic [YW-1:0]          o_yin,
  output logic [CW-1:0]          o_cin,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty,
  output logic                   o_busy,
  output logic                   o_overflow
);

  localparam int SW = seg_width(XW, YW, CW);

  logic [XW-1:0] xin, pen_x, hd_x0, hd_x1;
  logic [YW-1:0] yin, pen_y, hd_y0, hd_y1;
  logic [CW-1:0] cin, hd_col;
  logic          go_q, anchor, overflow;
  logic          commit, want_push, push_ok, drop, pen_move, pop;
  logic [SW-1:0] push_seg, head_seg;
  disp_state_t   state_q, state_d;

  assign commit    = i_go & ~go_q;
  assign want_push = commit & ~anchor;
  assign pop       = (state_q == IDLE) & ~o_empty;
  assign push_ok   = want_push & (~o_full | pop);
  assign drop      = want_push & ~push_ok;
  // An anchoring commit never pushes, so it moves the pen even when full.
  assign pen_move  = (commit & anchor) | push_ok;
  assign push_seg  = {xin, yin, pen_x, pen_y, cin};
  assign {hd_x0, hd_y0, hd_x1, hd_y1, hd_col} = head_seg;

  line_cmd_fifo #(.W(SW), .DEPTH(DEPTH)) u_fifo (
    .clk   (i_clk),
    .rst   (i_reset),
    .push  (push_ok),
    .pop   (pop),
    .din   (push_seg),
    .dout  (head_seg),
    .count (o_count),
    .full  (o_full),
    .empty (o_empty)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      xin      <= '0;
      yin      <= '0;
      cin      <= '0;
      go_q     <= 1'b0;
      pen_x    <= '0;
      pen_y    <= '0;
      anchor   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (i_setx)   xin <= i_val;
      if (i_sety)   yin <= i_val[YW-1:0];
      if (i_setcol) cin <= i_val[CW-1:0];
      go_q <= i_go;
      if (pen_move) begin
        pen_x <= xin;
        pen_y <= yin;
      end
      // Penup wins over clearing, so a same-cycle commit uses the old anchor.
      if (i_penup)               anchor <= 1'b1;
      else if (commit && anchor) anchor <= 1'b0;
      if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      o_x0    <= '0;
      o_y0    <= '0;
      o_x1    <= '0;
      o_y1    <= '0;
      o_color <= '0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        o_x0    <= hd_x0;
        o_y0    <= hd_y0;
        o_x1    <= hd_x1;
        o_y1    <= hd_y1;
        o_color <= hd_col;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!o_empty) state_d = START;
      START:   state_d = WAIT;
      WAIT:    if (i_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign o_start    = (state_q == START);
  assign o_busy     = (state_q != IDLE);
  assign o_xin      = xin;
  assign o_yin      = yin;
  assign o_cin      = cin;
  assign o_overflow = overflow;

endmodule
